// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types for the Sobel pixel window loader
package sobel_pkg;

   localparam int PIXEL_W = 8;

   typedef logic [PIXEL_W-1:0] pix_t;
   typedef logic [1:0]         idx_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      COMMIT,
      SHIFT,
      RELEASE
   } loader_state_e;

   typedef struct packed {
      idx_t row;
      idx_t col;
   } rc_t;

   // Row-major split of the initial-fill index 0..8 without a divider.
   function automatic rc_t init_idx_to_rc(input logic [3:0] idx);
      rc_t rc;
      if (idx >= 4'd6) begin
         rc.row = 2'd2;
         rc.col = 2'(idx - 4'd6);
      end else if (idx >= 4'd3) begin
         rc.row = 2'd1;
         rc.col = 2'(idx - 4'd3);
      end else begin
         rc.row = 2'd0;
         rc.col = 2'(idx);
      end
      return rc;
   endfunction

endpackage

// File: rtl/pixel_window_loader_if.sv
// rtl/pixel_window_loader_if.sv - held-request image memory read port
interface pixel_window_loader_if #(
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 16
);
   logic               mem_rd_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rd_valid;
   logic [PIXEL_W-1:0] mem_rd_data;

   modport master (output mem_rd_req, mem_addr, input mem_rd_valid, mem_rd_data);
   modport slave  (input mem_rd_req, mem_addr, output mem_rd_valid, mem_rd_data);
endinterface

// File: rtl/window_regs.sv
// rtl/window_regs.sv - 3x3 pixel register file with single write port and left shift
module window_regs #(
   parameter int PIXEL_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 we_i,
   input  sobel_pkg::idx_t      wr_row_i,
   input  sobel_pkg::idx_t      wr_col_i,
   input  logic [PIXEL_W-1:0]   wr_data_i,
   input  logic                 shift_i,
   output logic [9*PIXEL_W-1:0] window_o
);
   logic [PIXEL_W-1:0] win_q [3][3];

   always_ff @(posedge clk) begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (rst || clr_i) begin
               win_q[r][c] <= '0;
            end else if (shift_i) begin
               if (c < 2) win_q[r][c] <= win_q[r][c+1];
            end else if (we_i && wr_row_i == 2'(r) && wr_col_i == 2'(c)) begin
               win_q[r][c] <= wr_data_i;
            end
         end
      end
   end

   always_comb begin
      window_o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            window_o[(r*3+c)*PIXEL_W +: PIXEL_W] = win_q[r][c];
         end
      end
   end
endmodule

// File: rtl/pixel_window_loader.sv
// rtl/pixel_window_loader.sv - fetches pixels for the Sobel controller and maintains the 3x3 window
module pixel_window_loader #(
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_initial,
   input  logic [ADDR_W-1:0]     win_addr,
   input  logic [ADDR_W-1:0]     img_width,
   input  logic                  start_9_read,
   input  logic                  start_i_read,
   input  logic                  start_read,
   input  logic                  start_shift,
   output logic                  read_data_done,
   output logic                  read_done,
   output logic                  shift_done,
   pixel_window_loader_if.master mem,
   output logic [9*PIXEL_W-1:0]  window,
   output logic                  protocol_err
);
   import sobel_pkg::*;

   loader_state_e      state_q, state_d;
   logic [3:0]         init_idx_q, init_idx_d;
   idx_t               col_idx_q, col_idx_d;
   idx_t               src_r_q, src_r_d, src_c_q, src_c_d;
   logic               src_col_q, src_col_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [PIXEL_W-1:0] hold_q, hold_d;
   logic               hold_valid_q, hold_valid_d;
   logic               err_q, err_d;
   logic               rdd_q, rdd_d;
   logic               win_clr, win_we, win_shift;
   logic [3:0]         starts;
   rc_t                init_rc;

   function automatic logic [ADDR_W-1:0] row_off(input idx_t r, input logic [ADDR_W-1:0] w);
      case (r)
         2'd1:    row_off = w;
         2'd2:    row_off = w << 1;
         default: row_off = '0;
      endcase
   endfunction

   assign starts  = {start_shift, start_read, start_9_read, start_i_read};
   assign init_rc = init_idx_to_rc(init_idx_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         init_idx_q   <= '0;
         col_idx_q    <= '0;
         src_r_q      <= '0;
         src_c_q      <= '0;
         src_col_q    <= 1'b0;
         addr_q       <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         err_q        <= 1'b0;
         rdd_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         col_idx_q    <= col_idx_d;
         src_r_q      <= src_r_d;
         src_c_q      <= src_c_d;
         src_col_q    <= src_col_d;
         addr_q       <= addr_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         err_q        <= err_d;
         rdd_q        <= rdd_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      col_idx_d    = col_idx_q;
      src_r_d      = src_r_q;
      src_c_d      = src_c_q;
      src_col_d    = src_col_q;
      addr_d       = addr_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      err_d        = err_q;
      rdd_d        = 1'b0;
      win_clr      = 1'b0;
      win_we       = 1'b0;
      win_shift    = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_initial) begin
               win_clr      = 1'b1;
               init_idx_d   = '0;
               col_idx_d    = '0;
               hold_valid_d = 1'b0;
            end else begin
               if ($countones(starts) > 1) err_d = 1'b1;
               if (start_shift) begin
                  win_shift = 1'b1;
                  col_idx_d = '0;
                  state_d   = SHIFT;
               end else if (start_read) begin
                  // Window write and index advance happen on entry so the done pulse sees the new window.
                  if (hold_valid_q) begin
                     win_we = 1'b1;
                     if (src_col_q) col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
                     else init_idx_d = (init_idx_q == 4'd8) ? 4'd0 : init_idx_q + 4'd1;
                  end else begin
                     err_d = 1'b1;
                  end
                  hold_valid_d = 1'b0;
                  state_d      = COMMIT;
               end else if (start_9_read) begin
                  src_r_d   = init_rc.row;
                  src_c_d   = init_rc.col;
                  src_col_d = 1'b0;
                  addr_d    = win_addr + row_off(init_rc.row, img_width) + ADDR_W'(init_rc.col);
                  state_d   = REQ;
               end else if (start_i_read) begin
                  src_r_d   = col_idx_q;
                  src_c_d   = 2'd2;
                  src_col_d = 1'b1;
                  addr_d    = win_addr + row_off(col_idx_q, img_width) + ADDR_W'(2);
                  state_d   = REQ;
               end
            end
         end
         REQ, WAIT_DATA: begin
            if (mem.mem_rd_valid) begin
               hold_d       = mem.mem_rd_data;
               hold_valid_d = 1'b1;
               rdd_d        = 1'b1;
               state_d      = RELEASE;
            end else begin
               state_d = WAIT_DATA;
            end
         end
         COMMIT, SHIFT: state_d = RELEASE;
         RELEASE: if (starts == 4'b0000) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   window_regs #(.PIXEL_W(PIXEL_W)) u_window_regs (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (win_clr),
      .we_i      (win_we),
      .wr_row_i  (src_r_q),
      .wr_col_i  (src_c_q),
      .wr_data_i (hold_q),
      .shift_i   (win_shift),
      .window_o  (window)
   );

   assign mem.mem_rd_req = (state_q == REQ) || (state_q == WAIT_DATA);
   assign mem.mem_addr   = addr_q;
   assign read_data_done = rdd_q;
   assign read_done      = (state_q == COMMIT);
   assign shift_done     = (state_q == SHIFT);
   assign protocol_err   = err_q;
endmodule

// File: tb/tb_pixel_window_loader.sv
// tb/tb_pixel_window_loader.sv - scoreboard bench for pixel_window_loader
module tb_pixel_window_loader;
   import sobel_pkg::*;

   localparam int PW = 8;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst, load_initial;
   logic [AW-1:0] base, wid;
   logic          start_9_read, start_i_read, start_read, start_shift;
   logic          read_data_done, read_done, shift_done, protocol_err;
   logic [9*PW-1:0] window;

   int n_checks = 0;
   int n_errors = 0;

   pix_t          m_win [3][3];
   int            m_init, m_col, m_r, m_c;
   bit            m_hv, m_src_col;
   logic [AW-1:0] addr_sb [$];
   pix_t          pix_sb  [$];

   always #5 clk = ~clk;

   pixel_window_loader_if #(.PIXEL_W(PW), .ADDR_W(AW)) mif ();

   pixel_window_loader #(.PIXEL_W(PW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_initial   (load_initial),
      .win_addr       (base),
      .img_width      (wid),
      .start_9_read   (start_9_read),
      .start_i_read   (start_i_read),
      .start_read     (start_read),
      .start_shift    (start_shift),
      .read_data_done (read_data_done),
      .read_done      (read_done),
      .shift_done     (shift_done),
      .mem            (mif.master),
      .window         (window),
      .protocol_err   (protocol_err)
   );

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] pack_model();
      logic [71:0] p;
      p = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[(r*3+c)*8 +: 8] = m_win[r][c];
      return p;
   endfunction

   task automatic clear_model();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            m_win[r][c] = '0;
      m_init = 0;
      m_col  = 0;
      m_hv   = 1'b0;
      pix_sb.delete();
   endtask

   task automatic fetch(input bit col, input int lat, input int hold);
      logic [AW-1:0] ea;
      int r, c;
      if (col) begin r = m_col; c = 2; end
      else begin r = m_init / 3; c = m_init % 3; end
      ea = base + AW'(r) * wid + AW'(c);
      addr_sb.push_back(ea);
      pix_sb.push_back(ea[7:0]);
      if (col) start_i_read = 1'b1; else start_9_read = 1'b1;
      tick();
      ea = addr_sb.pop_front();
      check("req_rise", mif.mem_rd_req, 1);
      check("addr", mif.mem_addr, ea);
      for (int i = 0; i < lat; i++) begin
         tick();
         check("req_held", mif.mem_rd_req, 1);
         check("addr_stable", mif.mem_addr, ea);
      end
      mif.mem_rd_valid = 1'b1;
      mif.mem_rd_data  = mif.mem_addr[7:0];
      tick();
      mif.mem_rd_valid = 1'b0;
      check("req_drop", mif.mem_rd_req, 0);
      check("read_data_done", read_data_done, 1);
      m_hv = 1'b1; m_r = r; m_c = c; m_src_col = col;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("rdd_single", read_data_done, 0);
         check("no_rerequest", mif.mem_rd_req, 0);
      end
      start_9_read = 1'b0;
      start_i_read = 1'b0;
      tick();
      check("rdd_single", read_data_done, 0);
   endtask

   task automatic commit();
      if (m_hv) begin
         m_win[m_r][m_c] = pix_sb.pop_front();
         if (m_src_col) m_col = (m_col + 1) % 3;
         else m_init = (m_init + 1) % 9;
      end
      m_hv = 1'b0;
      start_read = 1'b1;
      tick();
      check("read_done", read_done, 1);
      check("window", window, pack_model());
      start_read = 1'b0;
      tick();
      check("read_done_single", read_done, 0);
      tick();
   endtask

   task automatic shift(input bit with_read);
      for (int r = 0; r < 3; r++) begin
         m_win[r][0] = m_win[r][1];
         m_win[r][1] = m_win[r][2];
      end
      m_col = 0;
      start_shift = 1'b1;
      start_read  = with_read;
      tick();
      check("shift_done", shift_done, 1);
      check("read_done_loses", read_done, 0);
      check("window_shift", window, pack_model());
      start_shift = 1'b0;
      start_read  = 1'b0;
      tick();
      check("shift_done_single", shift_done, 0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear_model();
   endtask

   initial begin
      rst = 1'b1; load_initial = 1'b0; base = '0; wid = '0;
      start_9_read = 1'b0; start_i_read = 1'b0; start_read = 1'b0; start_shift = 1'b0;
      mif.mem_rd_valid = 1'b0; mif.mem_rd_data = '0;
      do_reset();
      check("rst_req", mif.mem_rd_req, 0);
      check("rst_dones", {read_data_done, read_done, shift_done}, 0);
      check("rst_window", window, 0);
      check("rst_err", protocol_err, 0);

      // Initial fill: W=10, top-left at 100
      base = 16'd100; wid = 16'd10;
      load_initial = 1'b1;
      tick();
      load_initial = 1'b0;
      clear_model();
      tick();
      for (int i = 0; i < 9; i++) begin
         fetch(1'b0, 1, 0);
         commit();
      end
      check("fill_window", window, 72'h7A_79_78_70_6F_6E_66_65_64);

      // Column refill after a shift, window moved one pixel right
      base = 16'd101;
      shift(1'b0);
      for (int i = 0; i < 3; i++) begin
         fetch(1'b1, 1, 0);
         commit();
      end
      check("refill_window", window, 72'h7B_7A_79_71_70_6F_67_66_65);

      // Slow memory, then a start held well past its done
      fetch(1'b1, 5, 0);
      commit();
      fetch(1'b0, 1, 4);
      commit();
      check("no_err_yet", protocol_err, 0);

      // Simultaneous shift and read: shift wins, error flagged
      shift(1'b1);
      check("err_multi", protocol_err, 1);

      do_reset();
      check("err_cleared", protocol_err, 0);
      commit();
      check("err_no_hold", protocol_err, 1);

      // Reset while waiting for memory data
      do_reset();
      base = 16'd200; wid = 16'd10;
      start_9_read = 1'b1;
      tick();
      check("rw_req", mif.mem_rd_req, 1);
      check("rw_addr", mif.mem_addr, 200);
      rst = 1'b1;
      tick();
      check("rw_req_drop", mif.mem_rd_req, 0);
      rst = 1'b0;
      start_9_read = 1'b0;
      mif.mem_rd_valid = 1'b1;
      mif.mem_rd_data  = 8'hAB;
      tick();
      mif.mem_rd_valid = 1'b0;
      check("rw_late_ignored", {mif.mem_rd_req, read_data_done, read_done, shift_done, protocol_err}, 0);
      check("rw_window", window, 0);
      tick();
      check("rw_quiet", {mif.mem_rd_req, read_data_done}, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pixel_window_loader.md
# pixel_window_loader

Responder for the Sobel controller's pixel-fetch handshakes. It receives the `start_9_read`, `start_i_read`, `start_read`, `start_shift` and `load_initial` strobes and answers with `read_data_done`, `read_done` and `shift_done`. It fetches pixels from the image memory over a held-request read port and maintains the 3x3 pixel window consumed by the gradient units. It sits between the controller and the image memory, and feeds the horizontal/vertical gradient blocks.

## Interface
Parameters:
- `PIXEL_W`, 8: pixel width in bits.
- `ADDR_W`, 16: memory address width.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_initial`  in  1  clears `init_idx`, `col_idx`, the window and `holding_valid`.
- `win_addr`  in  ADDR_W  address of the window's top-left pixel. Sampled when a read request is issued.
- `img_width`  in  ADDR_W  pixels per image row, ≥3. Sampled when a read request is issued.
- `start_9_read`  in  1  level request: fetch the next initial-window pixel.
- `start_i_read`  in  1  level request: fetch the next right-column pixel.
- `start_read`  in  1  level request: commit the held pixel into the window.
- `start_shift`  in  1  level request: shift the window left by one column.
- `read_data_done`  out  1  one-cycle pulse: fetched pixel captured.
- `read_done`  out  1  one-cycle pulse: pixel committed to the window.
- `shift_done`  out  1  one-cycle pulse: shift complete.
- `mem_rd_req`  out  1  read request, held until `mem_rd_valid`.
- `mem_addr`  out  ADDR_W  read address, stable while `mem_rd_req` is high.
- `mem_rd_valid`  in  1  read data valid. Honoured only while `mem_rd_req` is high.
- `mem_rd_data`  in  PIXEL_W  read data.
- `window`  out  9*PIXEL_W  row-major window; p00 (top-left) in the LSBs, p22 in the MSBs.
- `protocol_err`  out  1  sticky error flag. Cleared only by `rst`.

## Operation
- FSM states: IDLE, REQ, WAIT_DATA, COMMIT, SHIFT, RELEASE.
- In IDLE, requests are served in this priority order: `start_shift` > `start_read` > `start_9_read` > `start_i_read`.
- `start_9_read`:
  - The pixel index is `init_idx` (0..8), row-major: row r = idx/3, column c = idx%3.
  - Address = `win_addr` + r*`img_width` + c. Compute r*W with shift/add only (0, W, W<<1). Arithmetic wraps mod 2^ADDR_W.
- `start_i_read`:
  - The pixel index is `col_idx` (0..2), which selects the row.
  - Address = `win_addr` + `col_idx`*`img_width` + 2.
- Fetch sequence: REQ drives the request → WAIT_DATA holds it → on `mem_rd_valid`, capture the data into the holding register and set `holding_valid` → pulse `read_data_done` → RELEASE.
- `start_read` (COMMIT):
  - Writes the holding register to window[r][c] for the source of the last fetch. An initial fetch writes to (r, c); a column fetch writes to (`col_idx`, 2).
  - Increments the matching index: `init_idx` wraps 8→0, `col_idx` wraps 2→0.
  - Clears `holding_valid` and pulses `read_done`.
- `start_shift`: window[r][0]←[r][1], window[r][1]←[r][2], window[r][2] unchanged. Clears `col_idx` and pulses `shift_done`.
- RELEASE waits until all four start inputs are low, then goes to IDLE. This prevents a level-held start from being served twice.
- `load_initial` is honoured only in IDLE. It is ignored, with no error, in any other state.
- `protocol_err` is set when:
  - `start_read` arrives with `holding_valid`=0. The window is not written, but `read_done` still pulses.
  - Two or more start inputs are high together in IDLE. The priority winner is still served.

## Timing
- Reset values: every output is 0, the window is all 0, the indices are 0, `holding_valid` is 0, and the state is IDLE.
- Start seen in IDLE at cycle 0 → `mem_rd_req` and `mem_addr` valid from cycle 1.
- `mem_rd_valid` at cycle k → `mem_rd_req` is low at k+1 and `read_data_done` pulses at k+1. The earliest valid is cycle 2.
- `start_read` / `start_shift` at cycle t → the window is updated and the done signal pulses at t+1.
- Every done signal is exactly one cycle wide. A new start is accepted no earlier than one cycle after its start input drops.
- `rst` in the middle of a transaction:
  - `mem_rd_req` drops the next cycle.
  - A `mem_rd_valid` arriving after the reset is ignored.
  - No done pulse is produced.

## Structure
- `sobel_pkg`: `PIXEL_W`, the loader state enum, the `pix_t` typedef, and the window index type (2-bit row/column).
- Sub-module `window_regs`: a 3x3 register file with a single-entry write port (row, column, data) and a left-shift control. The FSM, address generation and handshake logic stay in the top module.

## Test plan
- Initial fill: `load_initial`, then 9×(`start_9_read` → `start_read`) with W=10, `win_addr`=100, and memory returning data = addr[7:0]. Expect addresses 100, 101, 102, 110, 111, 112, 120, 121, 122, and the window equal to those bytes in row-major order.
- Column refill: after the fill, issue `start_shift`, then 3×(`start_i_read` → `start_read`) with `win_addr`=101. Expect `shift_done` 1 cycle after the shift, addresses 103, 113, 123, and right-column bytes 103, 113, 123.
- Memory latency: `mem_rd_valid` delayed 5 cycles. Expect `mem_rd_req` held with a stable address, and `read_data_done` exactly 1 cycle after valid.
- Held start: `start_9_read` kept high for 4 cycles after `read_data_done`. Expect a single memory request and no repeated pulse.
- Errors: `start_read` with no held data → `read_done` pulses, the window is unchanged, `protocol_err`=1. `start_shift` and `start_read` high together → the shift is served and `protocol_err`=1.
- Reset during WAIT_DATA → `mem_rd_req`=0 the next cycle, a late `mem_rd_valid` is ignored, and all outputs are 0.
